line_fill_demux8: RTL and testbench
===================================

# line_fill_demux8

Write-side counterpart of the 8-way line read mux in the set-associative cache. Collects a 64-byte refill line from the memory side as eight 64-bit beats, assembles it in a local buffer, then writes it into exactly one of the 8 ways with a one-hot write strobe. Sits between the miss handler / memory interface and the 8 way data arrays.

## Interface

Parameters:
- BEAT_W, 64, beat width in bits; only 64 supported
- BEATS, 8, beats per line; only 8 supported (line = 512 bits)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- fill_req  in  1  start a fill; sampled only in IDLE
- fill_way  in  3  destination way, latched with fill_req
- fill_word  in  3  critical-word index, latched with fill_req (see Configuration)
- fill_abort  in  1  cancel an in-progress fill; effective only in COLLECT
- fill_busy  out  1  high in any state other than IDLE
- beat_valid  in  1  memory side presents a beat
- beat_ready  out  1  block accepts a beat this cycle
- beat_data  in  64  beat payload
- way_we  out  8  one-hot write strobe to way arrays
- line_out  out  512  assembled line, valid while way_we != 0
- fill_done  out  1  one-cycle pulse, coincident with way_we

## Operation

- States: IDLE, COLLECT, WRITE.
- IDLE: beat_ready=0, way_we=0. fill_req=1 latches fill_way into way_q, loads ptr (start word), clears beat count cnt=0, goes to COLLECT.
- COLLECT: beat_ready=1. Beat accepted when beat_valid & beat_ready: beat_data stored in buffer slot ptr (bits ptr*64+63 : ptr*64), ptr increments modulo 8 (7 wraps to 0), cnt increments. On the 8th accepted beat go to WRITE.
- fill_abort=1 in COLLECT: return to IDLE, no write, no fill_done; abort takes priority over a beat accepted the same cycle (that beat discarded). fill_abort ignored in IDLE and WRITE.
- WRITE: way_we = 1 << way_q, line_out = buffer, fill_done=1, beat_ready=0; unconditionally back to IDLE next cycle.
- fill_req outside IDLE ignored (not queued). fill_way/fill_word changes after acceptance have no effect.
- Beats with beat_valid while beat_ready=0 are not consumed.
- line_out holds last buffer contents outside WRITE; consumers qualify with way_we.
- way_we is always zero or exactly one-hot.

## Timing

- Reset values: state IDLE, fill_busy=0, beat_ready=0, way_we=8'h00, line_out=0, fill_done=0, buffer/ptr/cnt=0.
- Reset asserted mid-fill: immediate return to reset values; partial line discarded; no way_we pulse.
- fill_req at cycle N -> beat_ready=1 from N+1. With beat_valid held high, beats accepted N+1..N+8; way_we and fill_done high at N+9 only; IDLE and new fill_req acceptable at N+10.
- Beat gaps (beat_valid low) stretch COLLECT one cycle each; no timeout.
- fill_busy high from N+1 through the WRITE cycle inclusive.
- All outputs registered; no combinational path from any input to any output.

## Configuration

- LINE_FILL_CWF_EN defined: critical-word-first; ptr starts at latched fill_word, beats fill slots fill_word, fill_word+1, ... wrapping 7 -> 0.
- Undefined: ptr always starts at 0; fill_word ignored; beats fill slots 0..7 in order.
- Beat count, latency and all other behaviour identical in both builds.

## Test plan

- Basic fill: fill_req, fill_way=5, beats 64'h0..64'h7 back-to-back -> way_we=8'h20 and fill_done for one cycle 9 cycles after fill_req, line_out slot k = k.
- Critical word (LINE_FILL_CWF_EN): fill_word=6, beats A0..A7 -> slot 6=A0, 7=A1, 0=A2, ..., 5=A7; without macro slot k=Ak.
- Stalls: beat_valid low 3 cycles between beats 2 and 3 -> way_we at 12 cycles after fill_req; beats not duplicated or dropped.
- Abort: fill_abort after 4 beats with beat_valid high -> IDLE next cycle, way_we stays 0, fill_done never pulses; subsequent fill to way 0 completes normally.
- Reset mid-fill: rst asserted after 5 beats -> all outputs zero immediately, no way_we; fill_req during COLLECT/WRITE ignored (single way_we pulse only).

Source files
------------

// File: rtl/line_fill_demux8_if.sv
// Refill-line bus between the miss handler / memory side (master) and the
// line fill demux (slave): fill control, beat stream and way write port.
interface line_fill_demux8_if;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned WAYS   = 8;
  localparam int unsigned WAY_W  = 3;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned LINE_W = BEAT_W * BEATS;

  logic              fill_req;
  logic [WAY_W-1:0]  fill_way;
  logic [PTR_W-1:0]  fill_word;
  logic              fill_abort;
  logic              fill_busy;
  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic [WAYS-1:0]   way_we;
  logic [LINE_W-1:0] line_out;
  logic              fill_done;

  modport master (
    output fill_req, fill_way, fill_word, fill_abort, beat_valid, beat_data,
    input  fill_busy, beat_ready, way_we, line_out, fill_done
  );

  modport slave (
    input  fill_req, fill_way, fill_word, fill_abort, beat_valid, beat_data,
    output fill_busy, beat_ready, way_we, line_out, fill_done
  );
endinterface

// File: rtl/line_fill_demux8.sv
// Collects eight 64-bit refill beats into a 512-bit line and writes it to one
// of eight ways with a one-hot strobe. LINE_FILL_CWF_EN enables critical-word-first.
module line_fill_demux8 #(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 8
) (
  input logic               clk,
  input logic               rst,
  line_fill_demux8_if.slave bus
);
  localparam int unsigned WAYS   = 8;
  localparam int unsigned WAY_W  = 3;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LINE_W = BEAT_W * BEATS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [WAYS-1:0]   we_q, we_d;
  logic              done_q, done_d;
  logic [PTR_W-1:0]  start_ptr;

  // Slot receiving the first beat of a fill.
`ifdef LINE_FILL_CWF_EN
  assign start_ptr = bus.fill_word;
`else
  logic unused_fill_word;
  assign start_ptr        = '0;
  assign unused_fill_word = ^bus.fill_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      way_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  // Outputs are registered from the next state so no input reaches an output combinationally.
  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (bus.fill_req) begin
          state_d = COLLECT;
          way_d   = bus.fill_way;
          ptr_d   = start_ptr;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        // Abort wins over a beat offered in the same cycle.
        if (bus.fill_abort) begin
          state_d = IDLE;
        end else if (bus.beat_valid && ready_q) begin
          for (int i = 0; i < int'(BEATS); i++) begin
            if (ptr_q == PTR_W'(i)) buf_d[i*BEAT_W +: BEAT_W] = bus.beat_data;
          end
          ptr_d = ptr_q + PTR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == COLLECT);
    done_d  = (state_d == WRITE);
    we_d    = done_d ? (WAYS'(1) << way_d) : '0;
  end

  assign bus.fill_busy  = busy_q;
  assign bus.beat_ready = ready_q;
  assign bus.way_we     = we_q;
  assign bus.line_out   = buf_q;
  assign bus.fill_done  = done_q;

  a_we_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(we_q));
  a_done_with_we: assert property (@(posedge clk) disable iff (rst) done_q == (we_q != '0));
endmodule

// File: tb/tb_line_fill_demux8.sv
// Randomized scoreboard bench for line_fill_demux8: a slot/latency reference
// model queues expected way writes; a negedge monitor pops and compares them.
module tb_line_fill_demux8;
`ifdef LINE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef logic [63:0] beat_arr_t [8];
  typedef int          gap_arr_t  [8];
  typedef struct {
    logic [7:0]   we;
    logic [511:0] line;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   writes_exp = 0;
  int   writes_seen = 0;
  exp_t q[$];

  line_fill_demux8_if bus ();
  line_fill_demux8 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_line(input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL line_out: got %0h expected %0h", act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest outstanding fill.
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.way_we !== 8'h00 || bus.fill_done !== 1'b0)) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_write: way_we=%0h fill_done=%0b with no fill outstanding",
                 bus.way_we, bus.fill_done);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("way_we", 64'(bus.way_we), 64'(e.we));
        chk("fill_done", 64'(bus.fill_done), 64'd1);
        chk_line(bus.line_out, e.line);
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        writes_seen++;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(bus.fill_busy),  64'd0);
    chk({tag, "_ready"}, 64'(bus.beat_ready), 64'd0);
    chk({tag, "_we"},    64'(bus.way_we),     64'd0);
    chk({tag, "_done"},  64'(bus.fill_done),  64'd0);
    chk_line(bus.line_out, '0);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_fill(input logic [2:0] way, input logic [2:0] word, input beat_arr_t b,
                         input gap_arr_t g, input int abort_at, input int rst_at,
                         input bit req_in_write);
    int           start;
    int           n;
    int           gsum;
    logic [511:0] l;
    exp_t         e;
    start = CWF ? int'(word) : 0;
    l = '0;
    for (int k = 0; k < 8; k++) l[((start + k) % 8) * 64 +: 64] = b[k];

    bus.fill_req  = 1'b1;
    bus.fill_way  = way;
    bus.fill_word = word;
    n = cyc;
    @(posedge clk); #1;
    bus.fill_req  = 1'b0;
    bus.fill_way  = 3'($urandom);
    bus.fill_word = 3'($urandom);
    chk("busy_after_req", 64'(bus.fill_busy), 64'd1);

    gsum = 0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < g[k]; j++) begin
        bus.beat_valid = 1'b0;
        bus.beat_data  = {$urandom, $urandom};
        bus.fill_req   = 1'($urandom);
        bus.fill_way   = 3'($urandom);
        @(posedge clk); #1;
        gsum++;
      end
      bus.fill_req = 1'b0;
      if (k == rst_at) begin
        bus.beat_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      bus.beat_valid = 1'b1;
      bus.beat_data  = b[k];
      chk("beat_ready", 64'(bus.beat_ready), 64'd1);
      if (k == abort_at) bus.fill_abort = 1'b1;
      @(posedge clk); #1;
      bus.fill_abort = 1'b0;
      if (k == abort_at) begin
        bus.beat_valid = 1'b0;
        chk("busy_after_abort", 64'(bus.fill_busy), 64'd0);
        chk("ready_after_abort", 64'(bus.beat_ready), 64'd0);
        return;
      end
    end

    e.we   = 8'(1) << way;
    e.line = l;
    e.cyc  = n + 9 + gsum;
    q.push_back(e);
    writes_exp++;

    bus.beat_valid = 1'($urandom);
    bus.beat_data  = {$urandom, $urandom};
    if (req_in_write) begin
      bus.fill_req = 1'b1;
      bus.fill_way = way + 3'd1;
    end
    chk("ready_in_write", 64'(bus.beat_ready), 64'd0);
    @(posedge clk); #1;
    bus.fill_req   = 1'b0;
    bus.beat_valid = 1'b0;
    chk("idle_after_write", 64'(bus.fill_busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_arr_t b;
    gap_arr_t  g;
    int        mode;
    int        ab;
    int        rs;

    rst            = 1'b1;
    bus.fill_req   = 1'b0;
    bus.fill_way   = '0;
    bus.fill_word  = '0;
    bus.fill_abort = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fill to way 5, beats 0..7 back-to-back.
    for (int k = 0; k < 8; k++) begin b[k] = 64'(k); g[k] = 0; end
    do_fill(3'd5, 3'd3, b, g, -1, -1, 1'b0);

    // Critical word 6, beats A0..A7.
    for (int k = 0; k < 8; k++) b[k] = 64'hA0A0_0000_0000_0000 | 64'(k);
    do_fill(3'd2, 3'd6, b, g, -1, -1, 1'b0);

    // Three-cycle stall between beats 2 and 3.
    for (int k = 0; k < 8; k++) b[k] = {$urandom, $urandom};
    g[3] = 3;
    do_fill(3'd7, 3'd1, b, g, -1, -1, 1'b0);
    g[3] = 0;

    // Abort after four accepted beats, then a normal fill to way 0.
    do_fill(3'd4, 3'd0, b, g, 4, -1, 1'b0);
    for (int k = 0; k < 8; k++) b[k] = {$urandom, $urandom};
    do_fill(3'd0, 3'd0, b, g, -1, -1, 1'b0);

    // Reset after five beats; then fill_req held through WRITE is ignored.
    do_fill(3'd3, 3'd2, b, g, -1, 5, 1'b0);
    g[1] = 2;
    do_fill(3'd1, 3'd5, b, g, -1, -1, 1'b1);
    g[1] = 0;

    for (int t = 0; t < 150; t++) begin
      for (int k = 0; k < 8; k++) begin
        b[k] = {$urandom, $urandom};
        g[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      mode = int'($urandom_range(0, 9));
      ab = (mode == 0) ? int'($urandom_range(0, 7)) : -1;
      rs = (mode == 1) ? int'($urandom_range(0, 7)) : -1;
      do_fill(3'($urandom), 3'($urandom), b, g, ab, rs, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("outstanding_writes", 64'(q.size()), 64'd0);
    chk("writes_seen", 64'(writes_seen), 64'(writes_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
